// File: rtl/hexdecode_2dig_monitor_if.sv
// Segment-bus and result-handshake bundle for the two-digit display loopback monitor.
// The master side drives the segments and consumer controls; the slave side is the monitor.
interface hexdecode_2dig_monitor_if;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       out_ready;
    logic       err_clr;
    logic [4:0] binary;
    logic       out_valid;
    logic       blank;
    logic       code_err;
    logic       range_err;
    logic       overrun;

    modport master (
        output hex1, hex0, out_ready, err_clr,
        input  binary, out_valid, blank, code_err, range_err, overrun
    );

    modport slave (
        input  hex1, hex0, out_ready, err_clr,
        output binary, out_valid, blank, code_err, range_err, overrun
    );
endinterface

// File: rtl/hexdecode_2dig_monitor.sv
// Watches the two active-low 7-segment digit buses, waits for a stable pattern and
// decodes it back to a 0..31 value delivered over valid/ready, with sticky error flags.
module hexdecode_2dig_monitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    hexdecode_2dig_monitor_if.slave        bus
);

    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_PRE = 8'(STABLE_CYCLES - 1);
    localparam logic [13:0] BLANK_PAIR = 14'h3FFF;

    // Returns {legal, digit}; only the ten exact digit glyphs are legal.
    function automatic logic [4:0] decodeDigit(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'b1_0000;
            7'b1111001: r = 5'b1_0001;
            7'b0100100: r = 5'b1_0010;
            7'b0110000: r = 5'b1_0011;
            7'b0011001: r = 5'b1_0100;
            7'b0010010: r = 5'b1_0101;
            7'b0000010: r = 5'b1_0110;
            7'b1111000: r = 5'b1_0111;
            7'b0000000: r = 5'b1_1000;
            7'b0011000: r = 5'b1_1001;
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [13:0] sample_q, sample_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  binary_q, binary_d;
    logic        valid_q, valid_d;
    logic        blank_q, blank_d;
    logic        codeErr_q, codeErr_d;
    logic        rangeErr_q, rangeErr_d;
    logic        overrun_q, overrun_d;
    logic [4:0]  last_q, last_d;
    logic        lastFull_q, lastFull_d;

    logic [13:0] patIn;
    logic        patMatch;
    logic        accept;
    logic [4:0]  tensDec;
    logic [4:0]  unitsDec;
    logic [6:0]  value;
    logic        bothLegal;
    logic        inRange;
    logic        push;
    logic        codeSet;
    logic        rangeSet;
    logic        overSet;

    always_comb begin
        patIn     = {bus.hex1, bus.hex0};
        patMatch  = (patIn == sample_q);
        sample_d  = patIn;
        if (!patMatch) begin
            cnt_d = '0;
        end else if (cnt_q >= STABLE_MAX) begin
            cnt_d = STABLE_MAX;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // Fires only on the edge the count reaches the threshold, so a held pattern accepts once.
        accept    = patMatch && (cnt_q == STABLE_PRE);
        tensDec   = decodeDigit(patIn[13:7]);
        unitsDec  = decodeDigit(patIn[6:0]);
        bothLegal = tensDec[4] && unitsDec[4];
        value     = 7'(tensDec[3:0]) * 7'd10 + 7'(unitsDec[3:0]);
        inRange   = (value <= 7'd31);
    end

    always_comb begin
        blank_d    = blank_q;
        last_d     = last_q;
        lastFull_d = lastFull_q;
        binary_d   = binary_q;
        valid_d    = valid_q;
        codeSet    = 1'b0;
        rangeSet   = 1'b0;
        overSet    = 1'b0;
        push       = 1'b0;

        if (accept) begin
            if (patIn == BLANK_PAIR) begin
                blank_d    = 1'b1;
                lastFull_d = 1'b0;
            end else if (!bothLegal) begin
                codeSet = 1'b1;
                blank_d = 1'b0;
            end else if (!inRange) begin
                rangeSet = 1'b1;
            end else begin
                blank_d    = 1'b0;
                push       = !lastFull_q || (last_q != value[4:0]);
                last_d     = value[4:0];
                lastFull_d = 1'b1;
            end
        end

        // A push in the same cycle as a transfer replaces the consumed value without overrun.
        if (push) begin
            binary_d = value[4:0];
            valid_d  = 1'b1;
            overSet  = valid_q && !bus.out_ready;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        codeErr_d  = (codeErr_q  && !bus.err_clr) || codeSet;
        rangeErr_d = (rangeErr_q && !bus.err_clr) || rangeSet;
        overrun_d  = (overrun_q  && !bus.err_clr) || overSet;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q   <= BLANK_PAIR;
            cnt_q      <= '0;
            binary_q   <= '0;
            valid_q    <= 1'b0;
            blank_q    <= 1'b0;
            codeErr_q  <= 1'b0;
            rangeErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            last_q     <= '0;
            lastFull_q <= 1'b0;
        end else begin
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            binary_q   <= binary_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            codeErr_q  <= codeErr_d;
            rangeErr_q <= rangeErr_d;
            overrun_q  <= overrun_d;
            last_q     <= last_d;
            lastFull_q <= lastFull_d;
        end
    end

    assign bus.binary    = binary_q;
    assign bus.out_valid = valid_q;
    assign bus.blank     = blank_q;
    assign bus.code_err  = codeErr_q;
    assign bus.range_err = rangeErr_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_hexdecode_2dig_monitor.sv
// Bench for hexdecode_2dig_monitor: a table of held segment patterns with expected outputs,
// a consumer-side scoreboard of delivered values, and hand sequences for reset and a fast build.
module tb_hexdecode_2dig_monitor;

    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D2  = 7'b0100100;
    localparam logic [6:0] D3  = 7'b0110000;
    localparam logic [6:0] D5  = 7'b0010010;
    localparam logic [6:0] D6  = 7'b0000010;
    localparam logic [6:0] D7  = 7'b1111000;
    localparam logic [6:0] BAD = 7'b0101010;
    localparam logic [6:0] BL  = 7'b1111111;

    typedef struct {
        string      name;
        logic [6:0] h1;
        logic [6:0] h0;
        logic       rdy;
        logic       clr;
        int         n;
        logic       v;
        logic [4:0] bin;
        logic       bl;
        logic       ce;
        logic       re;
        logic       ov;
        int         pushVal;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   expQ[$];
    int   expVal;
    int   edges;
    vec_t vecs[$];

    hexdecode_2dig_monitor_if busA();
    hexdecode_2dig_monitor_if busB();

    hexdecode_2dig_monitor #(.STABLE_CYCLES(4)) dutA (.clk(clk), .reset(reset), .bus(busA));
    hexdecode_2dig_monitor #(.STABLE_CYCLES(1)) dutB (.clk(clk), .reset(reset), .bus(busB));

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [6:0] h1, input logic [6:0] h0,
                          input logic rdy, input logic clr, input int n,
                          input logic v, input logic [4:0] bin, input logic bl,
                          input logic ce, input logic re, input logic ov, input int pushVal);
        vec_t t;
        t.name = name; t.h1 = h1; t.h0 = h0; t.rdy = rdy; t.clr = clr; t.n = n;
        t.v = v; t.bin = bin; t.bl = bl; t.ce = ce; t.re = re; t.ov = ov; t.pushVal = pushVal;
        vecs.push_back(t);
    endtask

    // Called at posedge+1; inputs are then seen by the next n edges and checked after the last.
    task automatic applyStimulus(input vec_t t);
        busA.hex1      = t.h1;
        busA.hex0      = t.h0;
        busA.out_ready = t.rdy;
        busA.err_clr   = t.clr;
        if (t.pushVal >= 0) expQ.push_back(t.pushVal);
        repeat (t.n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input vec_t t);
        checkField({t.name, ".out_valid"}, int'(busA.out_valid), int'(t.v));
        checkField({t.name, ".binary"},    int'(busA.binary),    int'(t.bin));
        checkField({t.name, ".blank"},     int'(busA.blank),     int'(t.bl));
        checkField({t.name, ".code_err"},  int'(busA.code_err),  int'(t.ce));
        checkField({t.name, ".range_err"}, int'(busA.range_err), int'(t.re));
        checkField({t.name, ".overrun"},   int'(busA.overrun),   int'(t.ov));
    endtask

    // A transfer happens on the coming edge; the delivered value must be the next expected one.
    always @(negedge clk) begin
        if (!reset && busA.out_valid && busA.out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL transfer: got %0d, expected no transfer", busA.binary);
            end else begin
                expVal = expQ.pop_front();
                checkField("transfer.binary", int'(busA.binary), expVal);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //        name          h1   h0   rdy clr n  v  bin bl ce re ov push
        addVec("s01_03_wait",   D0,  D3,  0, 0, 4, 0, 0,  0, 0, 0, 0, -1);
        addVec("s02_03_push",   D0,  D3,  0, 0, 1, 1, 3,  0, 0, 0, 0, 3);
        addVec("s03_03_take",   D0,  D3,  1, 0, 1, 0, 3,  0, 0, 0, 0, -1);
        addVec("s04_03_hold",   D0,  D3,  0, 0, 6, 0, 3,  0, 0, 0, 0, -1);
        addVec("s05_17_glitch", D1,  D7,  0, 0, 3, 0, 3,  0, 0, 0, 0, -1);
        addVec("s06_21_wait",   D2,  D1,  0, 0, 4, 0, 3,  0, 0, 0, 0, -1);
        addVec("s07_21_push",   D2,  D1,  0, 0, 1, 1, 21, 0, 0, 0, 0, 21);
        addVec("s08_21_take",   D2,  D1,  1, 0, 1, 0, 21, 0, 0, 0, 0, -1);
        addVec("s09_32_range",  D3,  D2,  0, 0, 5, 0, 21, 0, 0, 1, 0, -1);
        addVec("s10_1x_code",   D1,  BAD, 0, 0, 5, 0, 21, 0, 1, 1, 0, -1);
        addVec("s11_clear",     D1,  BAD, 0, 1, 1, 0, 21, 0, 0, 0, 0, -1);
        addVec("s12_x5_wait",   BL,  D5,  0, 0, 4, 0, 21, 0, 0, 0, 0, -1);
        addVec("s13_x5_setclr", BL,  D5,  0, 1, 1, 0, 21, 0, 1, 0, 0, -1);
        addVec("s14_clear",     BL,  D5,  0, 1, 1, 0, 21, 0, 0, 0, 0, -1);
        addVec("s15_05_push",   D0,  D5,  0, 0, 5, 1, 5,  0, 0, 0, 0, -1);
        addVec("s16_06_over",   D0,  D6,  0, 0, 5, 1, 6,  0, 0, 0, 1, 6);
        addVec("s17_07_wait",   D0,  D7,  0, 0, 4, 1, 6,  0, 0, 0, 1, -1);
        addVec("s18_07_pushrdy",D0,  D7,  1, 0, 1, 1, 7,  0, 0, 0, 1, 7);
        addVec("s19_07_take",   D0,  D7,  1, 0, 1, 0, 7,  0, 0, 0, 1, -1);
        addVec("s20_clear",     D0,  D7,  0, 1, 1, 0, 7,  0, 0, 0, 0, -1);
        addVec("s21_blank",     BL,  BL,  0, 0, 5, 0, 7,  1, 0, 0, 0, -1);
        addVec("s22_07_again",  D0,  D7,  0, 0, 5, 1, 7,  0, 0, 0, 0, 7);
        addVec("s23_07_take",   D0,  D7,  1, 0, 1, 0, 7,  0, 0, 0, 0, -1);
        addVec("s24_0x_code",   D0,  BAD, 0, 0, 5, 0, 7,  0, 1, 0, 0, -1);
        addVec("s25_07_nopush", D0,  D7,  0, 0, 5, 0, 7,  0, 1, 0, 0, -1);
        addVec("s26_clear",     D0,  D7,  0, 1, 1, 0, 7,  0, 0, 0, 0, -1);
        addVec("s27_31_push",   D3,  D1,  0, 0, 5, 1, 31, 0, 0, 0, 0, -1);

        busA.hex1 = BL; busA.hex0 = BL; busA.out_ready = 1'b0; busA.err_clr = 1'b0;
        busB.hex1 = BL; busB.hex0 = BL; busB.out_ready = 1'b0; busB.err_clr = 1'b0;

        #3;
        checkField("reset.out_valid", int'(busA.out_valid), 0);
        checkField("reset.binary",    int'(busA.binary),    0);
        checkField("reset.blank",     int'(busA.blank),     0);
        checkField("reset.code_err",  int'(busA.code_err),  0);
        checkField("reset.range_err", int'(busA.range_err), 0);
        checkField("reset.overrun",   int'(busA.overrun),   0);
        checkField("resetB.blank",    int'(busB.blank),     0);
        #10 reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Asynchronous reset between edges while a value is pending; it must not survive.
        #3 reset = 1'b1;
        #2;
        checkField("asyncReset.out_valid", int'(busA.out_valid), 0);
        checkField("asyncReset.binary",    int'(busA.binary),    0);
        #2 reset = 1'b0;
        edges = 0;
        while (!busA.out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkField("reaccept.edges",  edges,               5);
        checkField("reaccept.binary", int'(busA.binary),   31);
        expQ.push_back(31);
        busA.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busA.out_ready = 1'b0;
        checkField("reaccept.take.out_valid", int'(busA.out_valid), 0);

        checkField("fast.blank_idle", int'(busB.blank), 1);
        busB.hex1 = D0;
        busB.hex0 = D5;
        @(posedge clk);
        #1;
        checkField("fast.edge1.out_valid", int'(busB.out_valid), 0);
        @(posedge clk);
        #1;
        checkField("fast.edge2.out_valid", int'(busB.out_valid), 1);
        checkField("fast.edge2.binary",    int'(busB.binary),    5);
        checkField("fast.edge2.blank",     int'(busB.blank),     0);

        checkField("scoreboard.leftover", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
